// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the branch sequencer: default widths, FSM state
// encoding and the condition codes carried in br_sel / OC_fl.
package branch_sequencer_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 2 * DEF_DATA_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EVAL     = 3'd1,
    S_FETCH_LO = 3'd2,
    S_FETCH_HI = 3'd3,
    S_LOAD     = 3'd4,
    S_SKIP     = 3'd5
  } state_t;

  localparam logic [2:0] CC_Z  = 3'd0;
  localparam logic [2:0] CC_NZ = 3'd1;
  localparam logic [2:0] CC_C  = 3'd2;
  localparam logic [2:0] CC_NC = 3'd3;
  localparam logic [2:0] CC_P  = 3'd4;
  localparam logic [2:0] CC_N  = 3'd5;
  localparam logic [2:0] CC_PO = 3'd6;
  localparam logic [2:0] CC_PE = 3'd7;

endpackage

// File: rtl/branch_sequencer_if.sv
// Bundle of all non-clock/reset signals of the branch sequencer.
//   master : the sequencer (drives OC_fl, op_req, pc_load/pc_target/pc_skip,
//            busy, done; receives decoder strobe, FL and operand bytes)
//   slave  : the surroundings (decoder, flag register, fetch unit, PC)
interface branch_sequencer_if
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              br_start;
  logic              br_cond;
  logic [2:0]        br_sel;
  logic [2:0]        OC_fl;
  logic              FL;
  logic              op_req;
  logic              op_valid;
  logic [DATA_W-1:0] op_data;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              pc_skip;
  logic              busy;
  logic              done;

  modport master (
    input  br_start, br_cond, br_sel, FL, op_valid, op_data,
    output OC_fl, op_req, pc_load, pc_target, pc_skip, busy, done
  );

  modport slave (
    output br_start, br_cond, br_sel, FL, op_valid, op_data,
    input  OC_fl, op_req, pc_load, pc_target, pc_skip, busy, done
  );

endinterface

// File: rtl/branch_sequencer.sv
// Branch sequencer: reader side of the flag register. On a decoded jump it
// selects the condition (OC_fl), evaluates the returned FL bit, fetches a
// two-byte target for taken jumps and emits a one-cycle PC load or PC skip.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : branch_sequencer_if.master (decoder strobe, flag select/return,
//           operand stream handshake, PC load/skip, busy/done)
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_sequencer_if.master  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_op_req;
  logic              w_taken;

  logic [2:0]        r_oc_fl;
  logic              r_is_cond;
  logic [DATA_W-1:0] r_lo;
  logic [ADDR_W-1:0] r_pc_target;
  logic              r_pc_load;
  logic              r_pc_skip;
  logic              r_busy;
  logic              r_done;

  always_comb begin
    w_next   = r_state;
    w_op_req = 1'b0;
    w_taken  = ~r_is_cond | bus.FL;
    case (r_state)
      S_IDLE:     if (bus.br_start) w_next = S_EVAL;
      S_EVAL:     w_next = w_taken ? S_FETCH_LO : S_SKIP;
      S_FETCH_LO: begin
        w_op_req = 1'b1;
        if (bus.op_valid) w_next = S_FETCH_HI;
      end
      S_FETCH_HI: begin
        w_op_req = 1'b1;
        if (bus.op_valid) w_next = S_LOAD;
      end
      S_LOAD:     w_next = S_IDLE;
      S_SKIP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // coincide with the state they describe.
  // The high byte goes straight into the target register together with the
  // held low byte, so the target updates exactly on entry to LOAD and stays
  // untouched across not-taken jumps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_oc_fl     <= '0;
      r_is_cond   <= 1'b0;
      r_lo        <= '0;
      r_pc_target <= '0;
      r_pc_load   <= 1'b0;
      r_pc_skip   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != S_IDLE);
      r_pc_load <= (w_next == S_LOAD);
      r_pc_skip <= (w_next == S_SKIP);
      r_done    <= (w_next == S_LOAD) || (w_next == S_SKIP);
      if (r_state == S_IDLE && bus.br_start) begin
        r_oc_fl   <= bus.br_sel;
        r_is_cond <= bus.br_cond;
      end
      if (r_state == S_FETCH_LO && bus.op_valid)
        r_lo <= bus.op_data;
      if (r_state == S_FETCH_HI && bus.op_valid)
        r_pc_target <= {bus.op_data, r_lo};
    end
  end

  assign bus.OC_fl     = r_oc_fl;
  assign bus.op_req    = w_op_req;
  assign bus.pc_load   = r_pc_load;
  assign bus.pc_target = r_pc_target;
  assign bus.pc_skip   = r_pc_skip;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: expected PC outcomes are queued when a
// jump is started and checked when done pulses.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] flags;

  branch_sequencer_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  branch_sequencer #(.DATA_W(8), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Flag register model: returns the flag selected by OC_fl.
  assign bus.FL = flags[bus.OC_fl];

  always #5 clk = ~clk;

  typedef struct {
    bit          load;
    logic [15:0] tgt;
    int          lat;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int done_cyc;
  bit saw_req, saw_load, saw_skip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.op_req)  saw_req  = 1'b1;
    if (bus.pc_load) saw_load = 1'b1;
    if (bus.pc_skip) saw_skip = 1'b1;
    if (bus.done) begin
      done_cyc = cyc;
      chk("sb_empty_on_done", 32'(q.size() == 0), 32'd0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_load", 32'(bus.pc_load), 32'(e.load));
        chk("pc_skip", 32'(bus.pc_skip), 32'(!e.load));
        chk("pc_target", 32'(bus.pc_target), 32'(e.tgt));
        chk("latency", 32'(cyc), 32'(e.lat));
      end
    end
  endtask

  task automatic start(input bit cond, input logic [2:0] sel, input bit push,
                       input bit load, input logic [15:0] tgt, input int lat);
    exp_t e;
    bus.br_start = 1'b1;
    bus.br_cond  = cond;
    bus.br_sel   = sel;
    if (push) begin
      e.load = load; e.tgt = tgt; e.lat = lat;
      q.push_back(e);
    end
    cyc = 0; done_cyc = -1;
    saw_req = 1'b0; saw_load = 1'b0; saw_skip = 1'b0;
    step();
    bus.br_start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("op_req_wait", 32'(bus.op_req), 32'd1);
      step();
    end
    chk("op_req", 32'(bus.op_req), 32'd1);
    bus.op_valid = 1'b1;
    bus.op_data  = b;
    step();
    bus.op_valid = 1'b0;
    bus.op_data  = '0;
  endtask

  task automatic finish_jump(input int lat);
    chk("done_cycle", 32'(done_cyc), 32'(lat));
    step();
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("pulse_after", 32'({bus.pc_load, bus.pc_skip, bus.done}), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    flags        = '0;
    bus.br_start = 1'b0;
    bus.br_cond  = 1'b0;
    bus.br_sel   = '0;
    bus.op_valid = 1'b0;
    bus.op_data  = '0;
    cyc = 0; done_cyc = -1;
    repeat (3) step();
    chk("rst_outputs", 32'({bus.OC_fl, bus.op_req, bus.pc_load, bus.pc_skip, bus.busy, bus.done}), 32'd0);
    chk("rst_target", 32'(bus.pc_target), 32'd0);
    rst_n = 1'b1;
    step();

    // Unconditional jump, zero-wait operands.
    flags = '0;
    start(1'b0, CC_PE, 1'b1, 1'b1, 16'h1234, 4);
    chk("busy_eval", 32'(bus.busy), 32'd1);
    chk("oc_fl_uncond", 32'(bus.OC_fl), 32'(CC_PE));
    step();
    feed(8'h34, 0);
    feed(8'h12, 0);
    finish_jump(4);
    chk("uncond_no_skip", 32'(saw_skip), 32'd0);

    // Conditional Z taken, two wait cycles per byte.
    flags = 8'b0000_0001;
    start(1'b1, CC_Z, 1'b1, 1'b1, 16'hABCD, 8);
    chk("oc_fl_z", 32'(bus.OC_fl), 32'(CC_Z));
    step();
    feed(8'hCD, 2);
    feed(8'hAB, 2);
    finish_jump(8);

    // Conditional NC not taken.
    flags = 8'b1111_0111;
    start(1'b1, CC_NC, 1'b1, 1'b0, 16'hABCD, 2);
    chk("oc_fl_nc", 32'(bus.OC_fl), 32'(CC_NC));
    step();
    finish_jump(2);
    chk("nc_no_req", 32'(saw_req), 32'd0);
    chk("nc_no_load", 32'(saw_load), 32'd0);
    chk("nc_target_kept", 32'(bus.pc_target), 32'hABCD);

    // FL drops after EVAL: jump stays taken.
    flags = 8'b0000_0100;
    start(1'b1, CC_C, 1'b1, 1'b1, 16'h5678, 4);
    step();
    flags = '0;
    feed(8'h78, 0);
    feed(8'h56, 0);
    finish_jump(4);
    // Stray operand while idle must be ignored.
    bus.op_valid = 1'b1;
    bus.op_data  = 8'hEE;
    step();
    chk("stray_no_req", 32'(bus.op_req), 32'd0);
    step();
    bus.op_valid = 1'b0;
    chk("stray_idle", 32'(bus.busy), 32'd0);
    chk("stray_target", 32'(bus.pc_target), 32'h5678);

    // br_start during FETCH_HI and on the done cycle is ignored.
    start(1'b0, CC_PO, 1'b1, 1'b1, 16'h2468, 5);
    step();
    feed(8'h68, 0);
    bus.br_start = 1'b1;
    bus.br_sel   = CC_N;
    step();
    bus.br_start = 1'b0;
    chk("oc_fl_held", 32'(bus.OC_fl), 32'(CC_PO));
    feed(8'h24, 0);
    chk("done_cycle5", 32'(done_cyc), 32'd5);
    bus.br_start = 1'b1;
    bus.br_sel   = CC_PE;
    step();
    bus.br_start = 1'b0;
    chk("start_on_done_busy", 32'(bus.busy), 32'd0);
    chk("start_on_done_ocfl", 32'(bus.OC_fl), 32'(CC_PO));
    step();
    chk("start_on_done_idle", 32'(bus.busy), 32'd0);

    // Reset in FETCH_HI discards the partial target.
    start(1'b0, CC_NZ, 1'b0, 1'b0, 16'h0000, 0);
    step();
    feed(8'h55, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_target", 32'(bus.pc_target), 32'd0);
    chk("rst_mid_pulses", 32'({bus.pc_load, bus.pc_skip, bus.done, bus.op_req}), 32'd0);
    repeat (3) step();
    chk("rst_mid_no_load", 32'(saw_load), 32'd0);

    // Normal jump after the reset.
    start(1'b0, CC_P, 1'b1, 1'b1, 16'h9ABC, 4);
    step();
    feed(8'hBC, 0);
    feed(8'h9A, 0);
    finish_jump(4);

    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
